// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer: samples the random grid generator, snaps and clamps the sample into
// the playfield, queries the snake-body checker, retries on a hit and commits a food position.
// Optional build macro FOOD_BORDER_EN rejects candidates near the playfield edge without a query.
module food_spawn_ctrl #(
    parameter int GRID         = 10,
    parameter int X_MIN        = 20,
    parameter int X_MAX        = 620,
    parameter int Y_MIN        = 20,
    parameter int Y_MAX        = 460,
    parameter int MAX_TRIES    = 15,
    parameter int TRY_W        = 4,
    parameter int BORDER_CELLS = 2
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       spawn_req,
    input  logic [9:0] rand_X,
    input  logic [8:0] rand_Y,
    output logic       chk_req,
    output logic [9:0] chk_X,
    output logic [8:0] chk_Y,
    input  logic       chk_ack,
    input  logic       chk_hit,
    output logic [9:0] food_X,
    output logic [8:0] food_Y,
    output logic       food_valid,
    output logic       busy,
    output logic       spawn_done,
    output logic       spawn_fail,
    output logic [1:0] dbg_state
);

    // Checker handshake: chk_req with chk_X/chk_Y is held stable until the first cycle chk_ack=1
    // while chk_req=1; that cycle completes the transfer (zero-wait ack allowed), chk_ack is
    // ignored whenever chk_req=0.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_QUERY  = 2'd2
    } state_e;

    localparam logic [9:0]     GRID_X   = GRID[9:0];
    localparam logic [8:0]     GRID_Y   = GRID[8:0];
    localparam logic [9:0]     XMIN_V   = X_MIN[9:0];
    localparam logic [9:0]     XMAX_V   = X_MAX[9:0];
    localparam logic [8:0]     YMIN_V   = Y_MIN[8:0];
    localparam logic [8:0]     YMAX_V   = Y_MAX[8:0];
    localparam logic [TRY_W:0] MAX_T    = MAX_TRIES[TRY_W:0];
    localparam int             BORDER_PX = BORDER_CELLS * GRID;

    state_e           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             chk_req_q, chk_req_d;
    logic [9:0]       chk_x_q, chk_x_d;
    logic [8:0]       chk_y_q, chk_y_d;
    logic [9:0]       food_x_q, food_x_d;
    logic [8:0]       food_y_q, food_y_d;
    logic             food_valid_q, food_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    logic [9:0]       snap_x, cand_x;
    logic [8:0]       snap_y, cand_y;
    logic [TRY_W:0]   tries_inc;
    logic             last_try;

    always_comb begin
        snap_x = rand_X - (rand_X % GRID_X);
        snap_y = rand_Y - (rand_Y % GRID_Y);
        cand_x = (snap_x < XMIN_V) ? XMIN_V : ((snap_x > XMAX_V) ? XMAX_V : snap_x);
        cand_y = (snap_y < YMIN_V) ? YMIN_V : ((snap_y > YMAX_V) ? YMAX_V : snap_y);
    end

    // The try about to be spent is the last one when the incremented count reaches MAX_TRIES.
    assign tries_inc = {1'b0, tries_q} + 1'b1;
    assign last_try  = (tries_inc == MAX_T);

`ifdef FOOD_BORDER_EN
    localparam logic [9:0] XLO_B = XMIN_V + BORDER_PX[9:0];
    localparam logic [9:0] XHI_B = XMAX_V - BORDER_PX[9:0];
    localparam logic [8:0] YLO_B = YMIN_V + BORDER_PX[8:0];
    localparam logic [8:0] YHI_B = YMAX_V - BORDER_PX[8:0];
    logic in_border;
    assign in_border = (cand_x < XLO_B) || (cand_x > XHI_B) ||
                       (cand_y < YLO_B) || (cand_y > YHI_B);
`else
    localparam int BORDER_UNUSED = BORDER_PX;
`endif

    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        chk_req_d    = chk_req_q;
        chk_x_d      = chk_x_q;
        chk_y_d      = chk_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fail_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (spawn_req) begin
                    state_d      = S_SAMPLE;
                    food_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    tries_d      = '0;
                end
            end
            S_SAMPLE: begin
`ifdef FOOD_BORDER_EN
                if (in_border) begin
                    if (last_try) begin
                        state_d      = S_IDLE;
                        food_x_d     = cand_x;
                        food_y_d     = cand_y;
                        food_valid_d = 1'b1;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        fail_d       = 1'b1;
                    end else begin
                        tries_d = tries_inc[TRY_W-1:0];
                    end
                end else begin
                    chk_x_d   = cand_x;
                    chk_y_d   = cand_y;
                    chk_req_d = 1'b1;
                    state_d   = S_QUERY;
                end
`else
                chk_x_d   = cand_x;
                chk_y_d   = cand_y;
                chk_req_d = 1'b1;
                state_d   = S_QUERY;
`endif
            end
            S_QUERY: begin
                if (chk_ack) begin
                    chk_req_d = 1'b0;
                    if (!chk_hit || last_try) begin
                        state_d      = S_IDLE;
                        food_x_d     = chk_x_q;
                        food_y_d     = chk_y_q;
                        food_valid_d = 1'b1;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        fail_d       = chk_hit;
                    end else begin
                        tries_d = tries_inc[TRY_W-1:0];
                        state_d = S_SAMPLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tries_q      <= '0;
            chk_req_q    <= 1'b0;
            chk_x_q      <= '0;
            chk_y_q      <= '0;
            food_x_q     <= 10'd320;
            food_y_q     <= 9'd240;
            food_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            chk_req_q    <= chk_req_d;
            chk_x_q      <= chk_x_d;
            chk_y_q      <= chk_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign chk_req    = chk_req_q;
    assign chk_X      = chk_x_q;
    assign chk_Y      = chk_y_q;
    assign food_X     = food_x_q;
    assign food_Y     = food_y_q;
    assign food_valid = food_valid_q;
    assign busy       = busy_q;
    assign spawn_done = done_q;
    assign spawn_fail = fail_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Directed and randomized bench for food_spawn_ctrl against a behavioural placement model.
// Build with FOOD_BORDER_EN defined to exercise the edge-rejection variant instead.
module tb_food_spawn_ctrl;

    logic       VGA_clk = 1'b0;
    logic       reset;
    logic       spawn_req;
    logic [9:0] rand_X;
    logic [8:0] rand_Y;
    logic       chk_req;
    logic [9:0] chk_X;
    logic [8:0] chk_Y;
    logic       chk_ack;
    logic       chk_hit;
    logic [9:0] food_X;
    logic [8:0] food_Y;
    logic       food_valid;
    logic       busy;
    logic       spawn_done;
    logic       spawn_fail;
    logic [1:0] dbg_state;

    food_spawn_ctrl dut (
        .VGA_clk(VGA_clk), .reset(reset), .spawn_req(spawn_req),
        .rand_X(rand_X), .rand_Y(rand_Y),
        .chk_req(chk_req), .chk_X(chk_X), .chk_Y(chk_Y),
        .chk_ack(chk_ack), .chk_hit(chk_hit),
        .food_X(food_X), .food_Y(food_Y), .food_valid(food_valid),
        .busy(busy), .spawn_done(spawn_done), .spawn_fail(spawn_fail),
        .dbg_state(dbg_state)
    );

    always #5 VGA_clk = ~VGA_clk;

    localparam int MAX_TRIES = 15;

    int checks = 0;
    int errors = 0;
    int rx_q[$];
    int ry_q[$];
    bit hit_q[$];
    bit poke_spawn = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Playfield placement rule: floor to the cell pitch, then clamp into the legal range.
    function automatic int place(input int v, input int lo, input int hi);
        int c;
        c = (v / 10) * 10;
        if (c < lo) c = lo;
        if (c > hi) c = hi;
        return c;
    endfunction

    // Runs one spawn using the queued random samples and checker answers (one per query).
    task automatic do_spawn(input string tag, input int dmin, input int dmax);
        int  w, d, nq, ex, ey;
        bit  h, fin;
        ex = 0; ey = 0; h = 1'b0; nq = 0; fin = 1'b0;
        rand_X = 10'(rx_q[0]);
        rand_Y = 9'(ry_q[0]);
        spawn_req = 1'b1;
        @(negedge VGA_clk);
        spawn_req = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_valid_cleared"}, food_valid, 0);
        while (!fin) begin
            w = 0;
            while (!chk_req && w < 10) begin
                @(negedge VGA_clk);
                w++;
            end
            check({tag, "_query_latency"}, w, 1);
            if (!chk_req) begin
                rx_q.delete(); ry_q.delete(); hit_q.delete();
                return;
            end
            ex = place(rx_q.pop_front(), 20, 620);
            ey = place(ry_q.pop_front(), 20, 460);
            check({tag, "_chk_x"}, chk_X, ex);
            check({tag, "_chk_y"}, chk_Y, ey);
            d = $urandom_range(dmax, dmin);
            for (int i = 0; i < d; i++) begin
                if (poke_spawn) spawn_req = 1'b1;
                @(negedge VGA_clk);
            end
            spawn_req = 1'b0;
            if (d > 0) begin
                check({tag, "_chk_req_held"}, chk_req, 1);
                check({tag, "_chk_x_held"}, chk_X, ex);
            end
            h = hit_q.pop_front();
            nq++;
            chk_ack = 1'b1;
            chk_hit = h;
            if (rx_q.size() > 0) begin
                rand_X = 10'(rx_q[0]);
                rand_Y = 9'(ry_q[0]);
            end
            @(negedge VGA_clk);
            chk_ack = 1'b0;
            chk_hit = 1'b0;
            if (!h || nq == MAX_TRIES) fin = 1'b1;
        end
        check({tag, "_done"}, spawn_done, 1);
        check({tag, "_food_valid"}, food_valid, 1);
        check({tag, "_food_x"}, food_X, ex);
        check({tag, "_food_y"}, food_Y, ey);
        check({tag, "_fail"}, spawn_fail, h);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_chk_req_end"}, chk_req, 0);
        @(negedge VGA_clk);
        check({tag, "_done_pulse"}, spawn_done, 0);
        check({tag, "_fail_pulse"}, spawn_fail, 0);
        check({tag, "_valid_kept"}, food_valid, 1);
        rx_q.delete(); ry_q.delete(); hit_q.delete();
    endtask

    initial begin
        int  n, quiet;
        bit  saw;
        reset = 1'b1; spawn_req = 1'b0; rand_X = '0; rand_Y = '0;
        chk_ack = 1'b0; chk_hit = 1'b0;
        repeat (2) @(negedge VGA_clk);
        check("rst_food_x", food_X, 320);
        check("rst_food_y", food_Y, 240);
        check("rst_valid", food_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_chk_req", chk_req, 0);
        check("rst_chk_x", chk_X, 0);
        check("rst_done", spawn_done, 0);
        check("rst_fail", spawn_fail, 0);
        reset = 1'b0;
        @(negedge VGA_clk);

`ifdef FOOD_BORDER_EN
        rand_X = 10'd25; rand_Y = 9'd200;
        spawn_req = 1'b1;
        @(negedge VGA_clk);
        spawn_req = 1'b0;
        saw = 1'b0; n = 0;
        while (!spawn_done && n < 40) begin
            if (chk_req) saw = 1'b1;
            @(negedge VGA_clk);
            n++;
        end
        check("border_no_query", saw, 0);
        check("border_done", spawn_done, 1);
        check("border_fail", spawn_fail, 1);
        check("border_food_x", food_X, 20);
        check("border_food_y", food_Y, 200);
        check("border_busy", busy, 0);
`else
        rx_q = '{137}; ry_q = '{255}; hit_q = '{0};
        do_spawn("basic", 0, 0);

        rx_q = '{1000}; ry_q = '{5}; hit_q = '{0};
        do_spawn("clamp", 0, 1);

        rx_q = '{1023}; ry_q = '{511}; hit_q = '{0};
        do_spawn("clamp_top", 0, 0);

        rx_q = '{50, 70, 90}; ry_q = '{60, 80, 100}; hit_q = '{1, 1, 0};
        do_spawn("retry", 0, 2);

        for (int i = 0; i < MAX_TRIES; i++) begin
            rx_q.push_back($urandom_range(1023, 0));
            ry_q.push_back($urandom_range(511, 0));
            hit_q.push_back(1'b1);
        end
        do_spawn("exhaust", 0, 1);

        // Requests raised while a query is outstanding must not start another spawn.
        poke_spawn = 1'b1;
        rx_q = '{300}; ry_q = '{300}; hit_q = '{0};
        do_spawn("busy_ignore", 2, 2);
        poke_spawn = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (chk_req || busy) saw = 1'b1;
            @(negedge VGA_clk);
        end
        check("busy_ignore_quiet", saw, 0);

        rand_X = 10'd400; rand_Y = 9'd300;
        spawn_req = 1'b1;
        @(negedge VGA_clk);
        spawn_req = 1'b0;
        @(negedge VGA_clk);
        check("midrst_chk_req_pre", chk_req, 1);
        reset = 1'b1;
        #1;
        check("midrst_chk_req", chk_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_food_x", food_X, 320);
        check("midrst_valid", food_valid, 0);
        check("midrst_state", dbg_state, 0);
        @(negedge VGA_clk);
        reset = 1'b0;
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge VGA_clk);
            if (!spawn_done && !chk_req && !food_valid) quiet++;
        end
        check("midrst_no_commit", quiet, 5);

        for (int s = 0; s < 20; s++) begin
            n = ($urandom_range(7, 0) == 0) ? MAX_TRIES : $urandom_range(4, 1);
            for (int i = 0; i < n; i++) begin
                rx_q.push_back($urandom_range(1023, 0));
                ry_q.push_back($urandom_range(511, 0));
                hit_q.push_back((i < n - 1) ? 1'b1 : 1'(n == MAX_TRIES && $urandom_range(1, 0) == 1));
            end
            do_spawn($sformatf("rnd%0d", s), 0, 2);
            repeat ($urandom_range(2, 0)) @(negedge VGA_clk);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
